// File: rtl/wb_reg_bank.sv
// Write-back register bank: 8 GPRs (R0 hardwired to zero), two registered read ports and a
// pending-write scoreboard. Define WB_BYPASS_EN to enable write-to-read forwarding.
module wb_reg_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_wb,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              stall_a,
  output logic              stall_b,
  output logic [NREG-1:0]   busy_vec
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic [DATA_W-1:0] data_a_q;
  logic [DATA_W-1:0] data_a_d;
  logic [DATA_W-1:0] data_b_q;
  logic [DATA_W-1:0] data_b_d;

  logic wb_valid;
  logic issue_valid;
  logic bypass_hit_a;
  logic bypass_hit_b;

  // Writes and issues aimed at R0 are architectural no-ops.
  assign wb_valid    = wb_en && (wb_addr != '0);
  assign issue_valid = issue_en && (issue_addr != '0);

  // Register file and scoreboard next state.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_valid) begin
      regs_d[wb_addr] = ans_wb;
      busy_d[wb_addr] = 1'b0;
    end
    // A same-cycle issue marks a newer producer, so it overrides the clear.
    if (issue_valid) begin
      busy_d[issue_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  logic wb_hit_a;
  logic wb_hit_b;

  assign wb_hit_a = wb_valid && (wb_addr == rd_addr_a);
  assign wb_hit_b = wb_valid && (wb_addr == rd_addr_b);

  // Forwarded data is still used, but a same-cycle reissue keeps the operand stalled.
  assign bypass_hit_a = wb_hit_a && !(issue_en && (issue_addr == rd_addr_a));
  assign bypass_hit_b = wb_hit_b && !(issue_en && (issue_addr == rd_addr_b));

  always_comb begin
    data_a_d = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    data_b_d = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    if (wb_hit_a) begin
      data_a_d = ans_wb;
    end
    if (wb_hit_b) begin
      data_b_d = ans_wb;
    end
  end
`else
  assign bypass_hit_a = 1'b0;
  assign bypass_hit_b = 1'b0;

  always_comb begin
    data_a_d = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    data_b_d = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned n = 0; n < NREG; n++) begin
        regs_q[n] <= '0;
      end
      busy_q   <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a   = data_a_q;
  assign data_b   = data_b_q;
  assign busy_vec = busy_q;
  assign stall_a  = busy_q[rd_addr_a] && !bypass_hit_a;
  assign stall_b  = busy_q[rd_addr_b] && !bypass_hit_b;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed self-checking bench for wb_reg_bank; expectations follow WB_BYPASS_EN when defined.
module tb_wb_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ans_wb;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic       issue_en;
  logic [2:0] issue_addr;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       stall_a;
  logic       stall_b;
  logic [7:0] busy_vec;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  wb_reg_bank dut (
    .clk        (clk),
    .reset      (reset),
    .ans_wb     (ans_wb),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .data_a     (data_a),
    .data_b     (data_b),
    .stall_a    (stall_a),
    .stall_b    (stall_b),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en    = 1'b0;
    issue_en = 1'b0;
    wb_addr  = 3'd0;
    ans_wb   = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b0; wb_en = 1'b1; wb_addr = 3'd3; ans_wb = 8'hF0;
    issue_en = 1'b1; issue_addr = 3'd3; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
    step(); step();
    n_assert++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset data_a: got %h want 00", data_a); end
    n_assert++; if (data_b !== 8'h00) begin n_fail++; $display("FAIL reset data_b: got %h want 00", data_b); end
    n_assert++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset busy_vec: got %h want 00", busy_vec); end
    n_assert++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL reset stall_a: got %b want 0", stall_a); end
    idle();
    reset = 1'b1;
    step(); step();
    n_assert++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset no_write r3: got %h want 00", data_a); end
    n_assert++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset no_issue busy_vec: got %h want 00", busy_vec); end
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_addr = 3'd3; ans_wb = 8'hF0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    step();
    idle(); rd_addr_a = 3'd3;
    step();
    n_assert++; if (data_a !== 8'hF0) begin n_fail++; $display("FAIL write_read data_a: got %h want F0", data_a); end
    n_assert++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL write_read busy_vec: got %h want 00", busy_vec); end
    wb_en = 1'b1; wb_addr = 3'd0; ans_wb = 8'h0F; rd_addr_b = 3'd0; rd_addr_a = 3'd0;
    step();
    n_assert++; if (data_b !== 8'h00) begin n_fail++; $display("FAIL r0_bypass data_b: got %h want 00", data_b); end
    idle();
    step();
    n_assert++; if (data_b !== 8'h00) begin n_fail++; $display("FAIL r0_write data_b: got %h want 00", data_b); end
    n_assert++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL r0_write data_a: got %h want 00", data_a); end
  endtask

  task automatic test_scoreboard();
    issue_en = 1'b1; issue_addr = 3'd5; rd_addr_a = 3'd5; rd_addr_b = 3'd3;
    step();
    issue_en = 1'b0;
    #1;
    n_assert++; if (busy_vec !== 8'h20) begin n_fail++; $display("FAIL sb busy_vec: got %h want 20", busy_vec); end
    n_assert++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL sb stall_a: got %b want 1", stall_a); end
    n_assert++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL sb stall_b: got %b want 0", stall_b); end
    step();
    n_assert++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL sb stall_a hold: got %b want 1", stall_a); end
    wb_en = 1'b1; wb_addr = 3'd5; ans_wb = 8'h0F;
    #1;
    n_assert++; if (stall_a !== !Bypass) begin n_fail++; $display("FAIL sb stall_a wb cycle: got %b want %b", stall_a, !Bypass); end
    step();
    idle();
    #1;
    n_assert++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL sb stall_a cleared: got %b want 0", stall_a); end
    n_assert++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL sb busy cleared: got %h want 00", busy_vec); end
    step();
    n_assert++; if (data_a !== 8'h0F) begin n_fail++; $display("FAIL sb data_a: got %h want 0F", data_a); end
  endtask

  task automatic test_issue_wb_collision();
    issue_en = 1'b1; issue_addr = 3'd2; rd_addr_a = 3'd2; rd_addr_b = 3'd0;
    step();
    wb_en = 1'b1; wb_addr = 3'd2; ans_wb = 8'hAA;
    #1;
    // Reissue suppresses forwarding's stall release in every build.
    n_assert++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL coll stall_a: got %b want 1", stall_a); end
    step();
    idle();
    #1;
    n_assert++; if (busy_vec !== 8'h04) begin n_fail++; $display("FAIL coll busy_vec: got %h want 04", busy_vec); end
    step();
    n_assert++; if (data_a !== 8'hAA) begin n_fail++; $display("FAIL coll reg2: got %h want AA", data_a); end
    n_assert++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL coll stall_a after: got %b want 1", stall_a); end
    wb_en = 1'b1; wb_addr = 3'd2; ans_wb = 8'hAB;
    step();
    idle();
    #1;
    n_assert++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL coll busy release: got %h want 00", busy_vec); end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_addr = 3'd4; ans_wb = 8'h11; rd_addr_a = 3'd0; rd_addr_b = 3'd4;
    step();
    wb_en = 1'b1; wb_addr = 3'd4; ans_wb = 8'h5C; rd_addr_a = 3'd4;
    step();
    n_assert++;
    if (data_a !== (Bypass ? 8'h5C : 8'h11)) begin
      n_fail++; $display("FAIL bypass data_a: got %h want %h", data_a, Bypass ? 8'h5C : 8'h11);
    end
    n_assert++;
    if (data_b !== (Bypass ? 8'h5C : 8'h11)) begin
      n_fail++; $display("FAIL bypass data_b: got %h want %h", data_b, Bypass ? 8'h5C : 8'h11);
    end
    idle();
    step();
    n_assert++; if (data_a !== 8'h5C) begin n_fail++; $display("FAIL bypass settled: got %h want 5C", data_a); end
  endtask

  task automatic test_reset_mid();
    wb_en = 1'b1; wb_addr = 3'd1; ans_wb = 8'hF0;
    step();
    idle();
    issue_en = 1'b1; issue_addr = 3'd1;
    step();
    issue_addr = 3'd6;
    step();
    idle(); rd_addr_a = 3'd1; rd_addr_b = 3'd6;
    #1;
    n_assert++; if (busy_vec !== 8'h42) begin n_fail++; $display("FAIL midrst busy pre: got %h want 42", busy_vec); end
    step();
    n_assert++; if (data_a !== 8'hF0) begin n_fail++; $display("FAIL midrst reg1 pre: got %h want F0", data_a); end
    reset = 1'b0; wb_en = 1'b1; wb_addr = 3'd1; ans_wb = 8'h77;
    step();
    idle(); reset = 1'b1;
    #1;
    n_assert++; if (busy_vec !== 8'h00) begin n_fail++; $display("FAIL midrst busy_vec: got %h want 00", busy_vec); end
    n_assert++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL midrst stall_a: got %b want 0", stall_a); end
    n_assert++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL midrst stall_b: got %b want 0", stall_b); end
    step();
    n_assert++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL midrst reg1: got %h want 00", data_a); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_issue_wb_collision();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
